// File: rtl/easyaxi_slv_wr_ctrl.sv
// AXI write-channel slave: one outstanding burst into a small local word store.
// AW -> W beats -> B, with burst address generation and SLVERR detection.
module easyaxi_slv_wr_ctrl #(
  parameter  int MEM_DEPTH   = 16,
  localparam int AXI_ID_W    = 4,
  localparam int AXI_ADDR_W  = 32,
  localparam int AXI_LEN_W   = 8,
  localparam int AXI_SIZE_W  = 3,
  localparam int AXI_BURST_W = 2,
  localparam int AXI_RESP_W  = 2,
  localparam int AXI_DATA_W  = 64,
  localparam int AXI_USER_W  = 4,
  localparam int IDX_W       = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_awvalid,
  output logic                    axi_slv_awready,
  input  logic [AXI_ID_W-1:0]     axi_slv_awid,
  input  logic [AXI_ADDR_W-1:0]   axi_slv_awaddr,
  input  logic [AXI_LEN_W-1:0]    axi_slv_awlen,
  input  logic [AXI_SIZE_W-1:0]   axi_slv_awsize,
  input  logic [AXI_BURST_W-1:0]  axi_slv_awburst,
  input  logic [AXI_USER_W-1:0]   axi_slv_awuser,
  input  logic                    axi_slv_wvalid,
  output logic                    axi_slv_wready,
  input  logic [AXI_DATA_W-1:0]   axi_slv_wdata,
  input  logic [AXI_DATA_W/8-1:0] axi_slv_wstrb,
  input  logic                    axi_slv_wlast,
  input  logic [AXI_USER_W-1:0]   axi_slv_wuser,
  output logic                    axi_slv_bvalid,
  input  logic                    axi_slv_bready,
  output logic [AXI_ID_W-1:0]     axi_slv_bid,
  output logic [AXI_RESP_W-1:0]   axi_slv_bresp,
  output logic [AXI_USER_W-1:0]   axi_slv_buser,
  input  logic [IDX_W-1:0]        dbg_idx,
  output logic [AXI_DATA_W-1:0]   dbg_data
);

  localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(MEM_DEPTH * 8);
  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'd2;
  localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;
  state_t state, state_nxt;

  logic [AXI_ID_W-1:0]    aw_id_q;
  logic [AXI_LEN_W-1:0]   aw_len_q;
  logic [AXI_SIZE_W-1:0]  aw_size_q;
  logic [AXI_BURST_W-1:0] aw_burst_q;
  logic [AXI_USER_W-1:0]  aw_user_q;
  logic [AXI_ADDR_W-1:0]  beat_addr_q;
  logic [AXI_LEN_W:0]     beat_cnt_q;   // one extra bit so awlen=255 never wraps
  logic                   err_q;

  logic [AXI_DATA_W-1:0]  mem [MEM_DEPTH];

  logic aw_hs, w_hs, last_beat, aw_err, beat_err, wr_en, wrap_len_ok;
  logic [AXI_ADDR_W-1:0] addr_inc, wrap_bytes, wrap_mask, addr_nxt;
  logic [IDX_W-1:0]      widx;
  logic                  unused_wuser;

  assign unused_wuser = ^axi_slv_wuser;

  assign aw_hs = axi_slv_awvalid & axi_slv_awready;
  assign w_hs  = axi_slv_wvalid  & axi_slv_wready;

  assign last_beat = (beat_cnt_q == {1'b0, aw_len_q});

  assign wrap_len_ok = (axi_slv_awlen == 8'd1) || (axi_slv_awlen == 8'd3) ||
                       (axi_slv_awlen == 8'd7) || (axi_slv_awlen == 8'd15);

  assign aw_err = (axi_slv_awburst == BURST_RSVD) ||
                  (axi_slv_awsize > 3'd3) ||
                  ((axi_slv_awburst == BURST_WRAP) && !wrap_len_ok) ||
                  (axi_slv_awaddr >= MEM_BYTES);

  assign beat_err = (beat_addr_q >= MEM_BYTES) || (axi_slv_wlast != last_beat);
  assign wr_en    = w_hs && !err_q && !beat_err;
  assign widx     = beat_addr_q[3 +: IDX_W];

  // WRAP window is (awlen+1) << awsize bytes; legal lengths make it a power of two
  assign wrap_bytes = {{(AXI_ADDR_W-AXI_LEN_W-1){1'b0}}, ({1'b0, aw_len_q} + 9'd1)} << aw_size_q;
  assign wrap_mask  = wrap_bytes - 1'b1;
  assign addr_inc   = beat_addr_q + (AXI_ADDR_W'(1) << aw_size_q);

  always_comb begin
    addr_nxt = addr_inc;
    if (aw_burst_q == BURST_FIXED)
      addr_nxt = beat_addr_q;
    else if (aw_burst_q == BURST_WRAP)
      addr_nxt = (beat_addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    axi_slv_awready = 1'b0;
    axi_slv_wready  = 1'b0;
    axi_slv_bvalid  = 1'b0;
    case (state)
      S_IDLE: begin
        // held low while reset is asserted
        axi_slv_awready = rst_n;
        if (axi_slv_awvalid && rst_n) state_nxt = S_DATA;
      end
      S_DATA: begin
        axi_slv_wready = 1'b1;
        if (axi_slv_wvalid && last_beat) state_nxt = S_RESP;
      end
      S_RESP: begin
        axi_slv_bvalid = 1'b1;
        if (axi_slv_bready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_id_q     <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      aw_user_q   <= '0;
      beat_addr_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else if (aw_hs) begin
      aw_id_q     <= axi_slv_awid;
      aw_len_q    <= axi_slv_awlen;
      aw_size_q   <= axi_slv_awsize;
      aw_burst_q  <= axi_slv_awburst;
      aw_user_q   <= axi_slv_awuser;
      beat_addr_q <= axi_slv_awaddr;
      beat_cnt_q  <= '0;
      err_q       <= aw_err;
    end else if (w_hs) begin
      beat_addr_q <= addr_nxt;
      beat_cnt_q  <= beat_cnt_q + 1'b1;
      err_q       <= err_q | beat_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < AXI_DATA_W/8; b++)
        if (axi_slv_wstrb[b]) mem[widx][b*8 +: 8] <= axi_slv_wdata[b*8 +: 8];
    end
  end

  assign axi_slv_bid   = aw_id_q;
  assign axi_slv_buser = aw_user_q;
  assign axi_slv_bresp = err_q ? 2'b10 : 2'b00;
  assign dbg_data      = mem[dbg_idx];

endmodule

// File: doc/easyaxi_slv_wr_ctrl.md
EASYAXI_SLV_WR_CTRL -- requirements
Module: easyaxi_slv_wr_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, number of AXI_DATA_W-bit words in local storage; must be a power of two.
REQ-002 SHALL use widths AXI_ID_W=4, AXI_ADDR_W=32, AXI_LEN_W=8, AXI_SIZE_W=3, AXI_BURST_W=2, AXI_RESP_W=2, AXI_DATA_W=64, AXI_USER_W=4 from the shared define file.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 axi_slv_awvalid  in  1  AW valid.
REQ-006 axi_slv_awready  out  1  AW ready.
REQ-007 axi_slv_awid  in  AXI_ID_W  write ID.
REQ-008 axi_slv_awaddr  in  AXI_ADDR_W  start byte address.
REQ-009 axi_slv_awlen  in  AXI_LEN_W  beats minus one.
REQ-010 axi_slv_awsize  in  AXI_SIZE_W  log2 bytes per beat.
REQ-011 axi_slv_awburst  in  AXI_BURST_W  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-012 axi_slv_awuser  in  AXI_USER_W  user sideband; returned on buser.
REQ-013 axi_slv_wvalid  in  1  W valid.
REQ-014 axi_slv_wready  out  1  W ready.
REQ-015 axi_slv_wdata  in  AXI_DATA_W  write data.
REQ-016 axi_slv_wstrb  in  AXI_DATA_W/8  byte enables.
REQ-017 axi_slv_wlast  in  1  final beat marker.
REQ-018 axi_slv_wuser  in  AXI_USER_W  ignored.
REQ-019 axi_slv_bvalid  out  1  B valid.
REQ-020 axi_slv_bready  in  1  B ready.
REQ-021 axi_slv_bid  out  AXI_ID_W  captured awid.
REQ-022 axi_slv_bresp  out  AXI_RESP_W  2'b00 OKAY, 2'b10 SLVERR.
REQ-023 axi_slv_buser  out  AXI_USER_W  captured awuser.
REQ-024 dbg_idx  in  log2(MEM_DEPTH)  storage word index for inspection.
REQ-025 dbg_data  out  AXI_DATA_W  storage word at dbg_idx, combinational read.

Function
REQ-026 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, one outstanding write, no W acceptance before AW.
REQ-027 IDLE: awready=1, wready=0, bvalid=0; AW handshake captures awid/awaddr/awlen/awsize/awburst/awuser, clears beat counter and error flag, next state DATA.
REQ-028 DATA: awready=0, wready=1; each W handshake writes storage lane-by-lane per wstrb and increments beat counter; handshake with beat counter == awlen goes to RESP.
REQ-029 RESP: bvalid=1, bid/buser/bresp stable until B handshake; B handshake -> IDLE, awready=1 on following cycle.
REQ-030 Latency: AW handshake cycle N -> wready=1 at N+1; final W handshake cycle M -> bvalid=1 at M+1; max throughput one burst per awlen+3 cycles.
REQ-031 Word index = beat byte address[3 +: log2(MEM_DEPTH)]; wdata/wstrb applied to full word without lane steering.
REQ-032 Beat address: FIXED constant; INCR += 2^awsize; WRAP += 2^awsize wrapping within aligned (awlen+1)*2^awsize boundary.
REQ-033 Error flag set on: awburst=3; awsize>3; WRAP with awlen not in {1,3,7,15}; start address >= MEM_DEPTH*8; any beat address >= MEM_DEPTH*8; wlast != (beat counter == awlen).
REQ-034 Once error flag set, storage writes suppressed for remainder of burst; burst length always awlen+1 beats, wlast never ends burst early; bresp=SLVERR, else OKAY.
REQ-035 awlen=255 SHALL accept 256 beats; beat counter must not wrap before compare.
REQ-036 wvalid in IDLE or RESP SHALL be ignored (wready=0); awvalid in DATA/RESP SHALL stall (awready=0).

Reset
REQ-037 rst_n=0 at a clock edge: state IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, buser=0, all storage words 0; awready=1 first cycle after release.
REQ-038 Reset mid-burst or during RESP SHALL abandon the transaction with no B response and clear storage.

Verification
REQ-039 AW id=3 addr=0x10 len=0 INCR size=3, W data=0x1122334455667788 strb=0xFF last=1, bready=1 -> bvalid one cycle after W, bid=3 bresp=0, dbg_idx=2 reads written data.
REQ-040 INCR len=3 addr=0x0, 4 beats data=1..4 with wvalid gaps -> words 0..3 = 1..4, OKAY; bready held low 5 cycles -> bvalid/bid stable, awready=0 throughout.
REQ-041 WRAP len=3 size=3 addr=0x28 -> words 5,6,7,4 written in order; strb=0x0F on beat 2 -> only low 4 bytes of word 7 updated.
REQ-042 Errors: awburst=3, addr=0x80 (MEM_DEPTH=16), wlast=1 on beat 0 of len=1 -> each SLVERR, storage unchanged, burst still consumes awlen+1 beats.
REQ-043 Assert rst_n=0 after 2 of 4 beats -> next cycle wready=0 bvalid=0, storage 0, awready=1 after release; new AW accepted normally.
